alu_issue_stage: RTL and testbench

- ID/EX pipeline stage directly upstream of the ALU.
- Accepts a fetched MIPS instruction plus its register-file read values, and decodes the ALU controls `mode1`/`mode2`/`mode3`.
- Builds the two 32-bit ALU operands and registers everything behind a valid/ready handshake with flush.
- Also forwards writeback and memory control bits to later stages.

---
 rtl/alu_issue_stage_if.sv | 38 +++
 rtl/alu_issue_stage.sv | 167 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Handshake and data bundle between the fetch/regfile side, the ALU issue stage and the EX stage.
// The slave modport is the issue stage; the master modport is whoever drives it.
interface alu_issue_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic [1:0]        mode1;
    logic [1:0]        mode2;
    logic              mode3;
    logic [IDX_W-1:0]  dest_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] store_data;
    logic              illegal;

    modport slave (
        input  flush, in_valid, instr, rs_val, rt_val, out_ready,
        output in_ready, out_valid, a_out, b_out, mode1, mode2, mode3, dest_reg,
               reg_write, mem_read, mem_write, store_data, illegal
    );

    modport master (
        output flush, in_valid, instr, rs_val, rt_val, out_ready,
        input  in_ready, out_valid, a_out, b_out, mode1, mode2, mode3, dest_reg,
               reg_write, mem_read, mem_write, store_data, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX stage ahead of the ALU: decodes a MIPS instruction into ALU operands and mode controls
// and holds the result in a single valid/ready pipeline register with flush.
module alu_issue_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 5
) (
    input logic              clk,
    input logic              rst_n,
    alu_issue_stage_if.slave bus
);
    localparam logic [1:0] ModeAdd   = 2'b00;
    localparam logic [1:0] ModeShift = 2'b01;
    localparam logic [1:0] ModeLogic = 2'b10;

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       shamt;
    logic [15:0]      imm;
    logic [IDX_W-1:0] rt_idx;
    logic [IDX_W-1:0] rd_idx;

    assign opcode = bus.instr[31:26];
    assign rt_idx = bus.instr[20:16];
    assign rd_idx = bus.instr[15:11];
    assign shamt  = bus.instr[10:6];
    assign funct  = bus.instr[5:0];
    assign imm    = bus.instr[15:0];

    logic [DATA_W-1:0] a_d, b_d, sd_d;
    logic [1:0]        mode1_d, mode2_d;
    logic              mode3_d, rw_d, mr_d, mw_d, illegal_d;
    logic [IDX_W-1:0]  dest_d;

    logic [DATA_W-1:0] a_q, b_q, sd_q;
    logic [1:0]        mode1_q, mode2_q;
    logic              mode3_q, rw_q, mr_q, mw_q, illegal_q, out_valid_q;
    logic [IDX_W-1:0]  dest_q;

    always_comb begin
        a_d       = '0;
        b_d       = '0;
        sd_d      = '0;
        mode1_d   = ModeAdd;
        mode2_d   = 2'b00;
        mode3_d   = 1'b0;
        rw_d      = 1'b0;
        mr_d      = 1'b0;
        mw_d      = 1'b0;
        illegal_d = 1'b0;
        dest_d    = '0;
        case (opcode)
            6'h00: begin
                dest_d = rd_idx;
                rw_d   = 1'b1;
                a_d    = bus.rs_val;
                b_d    = bus.rt_val;
                case (funct)
                    6'h20, 6'h21: ;
                    6'h22, 6'h23: mode3_d = 1'b1;
                    6'h24, 6'h25, 6'h26, 6'h27: begin
                        mode1_d = ModeLogic;
                        mode2_d = funct[1:0];
                    end
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                        mode1_d = ModeShift;
                        a_d     = bus.rt_val;
                        // funct[2] selects the variable-amount form
                        b_d     = {{(DATA_W-5){1'b0}}, funct[2] ? bus.rs_val[4:0] : shamt};
                        case (funct[1:0])
                            2'b10:   mode2_d = 2'b01;
                            2'b11:   mode2_d = 2'b10;
                            default: mode2_d = 2'b00;
                        endcase
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h23, 6'h2B: begin
                a_d = bus.rs_val;
                b_d = {{(DATA_W-16){imm[15]}}, imm};
                if (opcode == 6'h2B) begin
                    mw_d = 1'b1;
                    sd_d = bus.rt_val;
                end else begin
                    dest_d = rt_idx;
                    rw_d   = 1'b1;
                    mr_d   = (opcode == 6'h23);
                end
            end
            6'h0C, 6'h0D, 6'h0E: begin
                a_d     = bus.rs_val;
                b_d     = {{(DATA_W-16){1'b0}}, imm};
                mode1_d = ModeLogic;
                mode2_d = opcode[1:0];
                dest_d  = rt_idx;
                rw_d    = 1'b1;
            end
            6'h0F: begin
                a_d     = {{(DATA_W-16){1'b0}}, imm};
                b_d     = DATA_W'(16);
                mode1_d = ModeShift;
                dest_d  = rt_idx;
                rw_d    = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase
        if (illegal_d) begin
            a_d     = '0;
            b_d     = '0;
            mode1_d = ModeAdd;
            mode2_d = 2'b00;
            mode3_d = 1'b0;
            dest_d  = '0;
            rw_d    = 1'b0;
        end
        if (dest_d == '0) rw_d = 1'b0;
    end

    assign bus.in_ready = !out_valid_q || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sd_q        <= '0;
            mode1_q     <= 2'b00;
            mode2_q     <= 2'b00;
            mode3_q     <= 1'b0;
            rw_q        <= 1'b0;
            mr_q        <= 1'b0;
            mw_q        <= 1'b0;
            illegal_q   <= 1'b0;
            dest_q      <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (bus.in_valid && bus.in_ready) begin
            out_valid_q <= 1'b1;
            a_q         <= a_d;
            b_q         <= b_d;
            sd_q        <= sd_d;
            mode1_q     <= mode1_d;
            mode2_q     <= mode2_d;
            mode3_q     <= mode3_d;
            rw_q        <= rw_d;
            mr_q        <= mr_d;
            mw_q        <= mw_d;
            illegal_q   <= illegal_d;
            dest_q      <= dest_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.mode1      = mode1_q;
    assign bus.mode2      = mode2_q;
    assign bus.mode3      = mode3_q;
    assign bus.dest_reg   = dest_q;
    assign bus.reg_write  = rw_q;
    assign bus.mem_read   = mr_q;
    assign bus.mem_write  = mw_q;
    assign bus.store_data = sd_q;
    assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomised and directed bench for alu_issue_stage: a driver pushes expected entries on every
// accepted instruction and a monitor pops and compares each entry as it leaves the stage.
module tb_alu_issue_stage;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  m1;
        logic [1:0]  m2;
        logic        m3;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] sd;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    alu_issue_stage_if bus ();
    alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference decode written straight from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs,
                                   input logic [31:0] rt);
        exp_t        e;
        logic [5:0]  op, fn;
        logic [31:0] sext, zext;
        logic        ok;
        op   = ins[31:26];
        fn   = ins[5:0];
        sext = {{16{ins[15]}}, ins[15:0]};
        zext = {16'h0, ins[15:0]};
        e    = '0;
        ok   = 1'b1;
        if (op == 6'h00) begin
            e.dest = ins[15:11];
            e.rw   = 1'b1;
            if (fn == 6'h20 || fn == 6'h21) begin e.a = rs; e.b = rt; end
            else if (fn == 6'h22 || fn == 6'h23) begin e.a = rs; e.b = rt; e.m3 = 1'b1; end
            else if (fn >= 6'h24 && fn <= 6'h27) begin
                e.a = rs; e.b = rt; e.m1 = 2'b10; e.m2 = 2'(fn - 6'h24);
            end else if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03 ||
                         fn == 6'h04 || fn == 6'h06 || fn == 6'h07) begin
                e.a  = rt;
                e.b  = (fn >= 6'h04) ? (rs % 32) : 32'(ins[10:6]);
                e.m1 = 2'b01;
                e.m2 = (fn == 6'h00 || fn == 6'h04) ? 2'd0 :
                       (fn == 6'h02 || fn == 6'h06) ? 2'd1 : 2'd2;
            end else ok = 1'b0;
        end else if (op == 6'h08 || op == 6'h09) begin
            e.a = rs; e.b = sext; e.dest = ins[20:16]; e.rw = 1'b1;
        end else if (op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
            e.a = rs; e.b = zext; e.m1 = 2'b10; e.m2 = 2'(op - 6'h0C);
            e.dest = ins[20:16]; e.rw = 1'b1;
        end else if (op == 6'h0F) begin
            e.a = zext; e.b = 32'd16; e.m1 = 2'b01; e.dest = ins[20:16]; e.rw = 1'b1;
        end else if (op == 6'h23) begin
            e.a = rs; e.b = sext; e.dest = ins[20:16]; e.rw = 1'b1; e.mr = 1'b1;
        end else if (op == 6'h2B) begin
            e.a = rs; e.b = sext; e.mw = 1'b1; e.sd = rt;
        end else ok = 1'b0;
        if (!ok) begin
            e = '0;
            e.ill = 1'b1;
        end
        if (e.dest == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = '{a: bus.a_out, b: bus.b_out, m1: bus.mode1, m2: bus.mode2, m3: bus.mode3,
              dest: bus.dest_reg, rw: bus.reg_write, mr: bus.mem_read, mw: bus.mem_write,
              sd: bus.store_data, ill: bus.illegal};
        return o;
    endfunction

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt,
                                          input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entry leaves the stage when consumed or flushed; its contents are still intact here.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && (bus.out_ready || bus.flush)) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_entry: got %h expected none", observed());
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (observed() !== e) begin
                    fails++;
                    $display("FAIL entry: got %h expected %h", observed(), e);
                end
            end
        end
    end

    // Called at posedge+1; leaves at the next posedge+1.
    task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input logic iv, input logic ordy, input logic fl, output logic acc);
        bus.instr     = ins;
        bus.rs_val    = rs;
        bus.rt_val    = rt;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(negedge clk);
        acc = iv && bus.in_ready && !fl;
        if (acc) sb.push_back(model(ins, rs, rt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc, acc2;
        exp_t        snap;
        logic [5:0]  ops [8] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        logic [5:0]  fns [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                  6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27};
        bus.instr = '0; bus.rs_val = '0; bus.rt_val = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
        #2;
        chk("reset_valid", 32'(bus.out_valid), 0);
        chk("reset_fields", 32'(observed() != '0), 0);
        chk("reset_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        drive(32'h00221820, 5, 7, 1, 1, 0, acc);
        chk("add_valid", 32'(bus.out_valid), 1);
        chk("add_a", bus.a_out, 5);
        chk("add_b", bus.b_out, 7);
        chk("add_dest", 32'(bus.dest_reg), 3);
        chk("add_rw", 32'(bus.reg_write), 1);

        drive(32'h00221822, 9, 4, 1, 1, 0, acc);
        chk("sub_m3", 32'(bus.mode3), 1);
        drive(rtype(0, 5, 4, 3, 6'h03), 0, 32'h80000000, 1, 1, 0, acc2);
        chk("b2b_accepts", 32'({acc, acc2}), 3);
        chk("sra_a", bus.a_out, 32'h80000000);
        chk("sra_b", bus.b_out, 3);
        chk("sra_modes", 32'({bus.mode1, bus.mode2}), 32'b0110);
        chk("sra_dest", 32'(bus.dest_reg), 4);

        drive(itype(6'h08, 1, 2, 16'hFFFC), 1, 0, 1, 1, 0, acc);
        chk("addi_b", bus.b_out, 32'hFFFFFFFC);
        drive(itype(6'h0D, 1, 2, 16'h8000), 1, 0, 1, 1, 0, acc);
        chk("ori_b", bus.b_out, 32'h00008000);
        chk("ori_m2", 32'(bus.mode2), 1);
        drive(itype(6'h0F, 0, 2, 16'h1234), 0, 0, 1, 1, 0, acc);
        chk("lui_a", bus.a_out, 32'h00001234);
        chk("lui_b", bus.b_out, 16);
        chk("lui_modes", 32'({bus.mode1, bus.mode2}), 32'b0100);

        // Stall with a new instruction waiting, then release it
        snap = observed();
        for (int i = 0; i < 3; i++) begin
            drive(rtype(1, 2, 6, 0, 6'h25), 32'h0F0F, 32'hF000, 1, 0, 0, acc);
            chk("stall_in_ready", 32'(bus.in_ready), 0);
            chk("stall_hold", 32'(observed() != snap), 0);
            chk("stall_valid", 32'(bus.out_valid), 1);
        end
        drive(rtype(1, 2, 6, 0, 6'h25), 32'h0F0F, 32'hF000, 1, 1, 0, acc);
        chk("stall_release_acc", 32'(acc), 1);
        chk("stall_release_a", bus.a_out, 32'h0F0F);

        drive(rtype(1, 2, 7, 0, 6'h20), 1, 1, 1, 0, 1, acc);
        chk("flush_valid", 32'(bus.out_valid), 0);
        drive('0, 0, 0, 0, 1, 0, acc);
        chk("flush_dropped", 32'(bus.out_valid), 0);

        drive(rtype(1, 2, 0, 0, 6'h3F), 3, 3, 1, 1, 0, acc);
        chk("illegal_flag", 32'(bus.illegal), 1);
        chk("illegal_rw", 32'(bus.reg_write), 0);
        drive(rtype(1, 2, 0, 0, 6'h20), 3, 3, 1, 1, 0, acc);
        chk("rd0_rw", 32'(bus.reg_write), 0);
        drive(itype(6'h2B, 1, 9, 16'h0010), 32'h100, 32'hCAFE, 1, 1, 0, acc);
        chk("sw_sd", bus.store_data, 32'hCAFE);

        drive(itype(6'h23, 1, 9, 16'h0004), 32'h200, 0, 1, 0, 0, acc);
        drive(rtype(1, 2, 3, 0, 6'h20), 1, 1, 1, 0, 0, acc);
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus.out_valid), 0);
        chk("rst_mid_fields", 32'(observed() != '0), 0);
        sb.delete();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            int          k;
            ins = $urandom;
            k   = $urandom_range(0, 23);
            if (k < 14) ins = {6'h00, ins[25:6], fns[k]};
            else if (k < 22) ins[31:26] = ops[k-14];
            else if (k == 22) ins[5:0] = 6'h3F;
            else ins[31:26] = 6'h02;
            if (k == 22) ins[31:26] = 6'h00;
            drive(ins, $urandom, $urandom, ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), acc);
        end

        for (int i = 0; i < 20 && bus.out_valid; i++) drive('0, 0, 0, 0, 1, 0, acc);
        chk("drain_valid", 32'(bus.out_valid), 0);
        chk("drain_queue", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
